// File: rtl/iir1_lpf_mc.sv
`default_nettype none
// ============================================================================
// Module   : iir1_lpf_mc
// Brief    : Time-multiplexed multi-channel first-order IIR low-pass filter,
//            y(n) = a*x(n) + (1-a)*y(n-1), a = i_coef/2^CW, three-stage
//            pipeline with per-channel state bank and S3->S2 forwarding.
//            Optional build macro IIR1_ROUND_EN selects round-half-up at both
//            right shifts (default: truncation).
// Revision : 1.0 - initial release
// ============================================================================
module iir1_lpf_mc #(
  parameter int DW = 8,
  parameter int CW = 2,
  parameter int CH = 4,
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_clr,
  input  logic           i_valid,
  input  logic [CHW-1:0] i_ch,
  input  logic [DW-1:0]  i_data,
  input  logic [CW:0]    i_coef,
  output logic           o_valid,
  output logic [CHW-1:0] o_ch,
  output logic [DW-1:0]  o_y
);

  // State holds y scaled by 2^CW; the product needs two fractional fields
  // plus one guard bit so a full-scale sum cannot wrap.
  localparam int SW = DW + CW;
  localparam int PW = DW + 2 * CW + 1;
  localparam logic [CW:0]  A_ONE  = (CW + 1)'(1) << CW;
  localparam logic [CHW:0] CH_LIM = (CHW + 1)'(CH);

  // Stage 1 registers: accepted sample and clamped coefficient
  logic           v1;
  logic [CHW-1:0] ch1;
  logic [DW-1:0]  d1;
  logic [CW:0]    a1;

  // Stage 2 registers: both partial products
  logic           v2;
  logic [CHW-1:0] ch2;
  logic [PW-1:0]  px2;
  logic [PW-1:0]  ps2;

  // Per-channel state bank
  logic [SW-1:0]  st [CH];

  logic           in_ok;
  logic           fwd;
  logic [SW-1:0]  s_rd;
  logic [PW-1:0]  px_c;
  logic [PW-1:0]  ps_c;
  logic [PW-1:0]  prod;
  logic [SW-1:0]  s_new;
  logic [DW-1:0]  y_new;

  assign in_ok = ({1'b0, i_ch} < CH_LIM);

  // Stage 2 product formation; the sample one stage ahead on the same
  // channel has not written the bank yet, so take its fresh state instead
  always_comb begin
    fwd  = v2 && (ch2 == ch1);
    s_rd = fwd ? s_new : st[ch1];
    px_c = (PW'(a1) * PW'(d1)) << CW;
    ps_c = PW'(A_ONE - a1) * PW'(s_rd);
  end

`ifdef IIR1_ROUND_EN
  localparam logic [PW-1:0] P_HALF = PW'(1) << (CW - 1);
  localparam logic [SW:0]   S_HALF = (SW + 1)'(1) << (CW - 1);
  localparam logic [DW:0]   Y_MAX  = (DW + 1)'((1 << DW) - 1);

  logic [PW-1:0] prod_r;
  logic [SW:0]   s_r;
  logic [DW:0]   y_w;

  // Stage 3 sum with round-half-up at both shifts; output clamp kept as a guard
  always_comb begin
    prod   = px2 + ps2;
    prod_r = prod + P_HALF;
    s_new  = SW'(prod_r >> CW);
    s_r    = (SW + 1)'(s_new) + S_HALF;
    y_w    = (DW + 1)'(s_r >> CW);
    y_new  = (y_w > Y_MAX) ? DW'(Y_MAX) : DW'(y_w);
  end
`else
  // Stage 3 sum with truncating shifts
  always_comb begin
    prod  = px2 + ps2;
    s_new = SW'(prod >> CW);
    y_new = DW'(s_new >> CW);
  end
`endif

  // Pipeline registers; clear flushes every valid, data fields just hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      ch1     <= '0;
      d1      <= '0;
      a1      <= '0;
      v2      <= 1'b0;
      ch2     <= '0;
      px2     <= '0;
      ps2     <= '0;
      o_valid <= 1'b0;
      o_ch    <= '0;
      o_y     <= '0;
    end else if (i_clr) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      v1 <= i_valid && in_ok;
      if (i_valid && in_ok) begin
        ch1 <= i_ch;
        d1  <= i_data;
        a1  <= (i_coef > A_ONE) ? A_ONE : i_coef;
      end
      v2 <= v1;
      if (v1) begin
        ch2 <= ch1;
        px2 <= px_c;
        ps2 <= ps_c;
      end
      o_valid <= v2;
      if (v2) begin
        o_ch <= ch2;
        o_y  <= y_new;
      end
    end
  end

  // Channel state bank: written from stage 3, wiped by reset or clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) st[c] <= '0;
    end else if (i_clr) begin
      for (int c = 0; c < CH; c++) st[c] <= '0;
    end else if (v2) begin
      st[ch2] <= s_new;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iir1_lpf_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_iir1_lpf_mc
// Brief    : Self-checking bench for iir1_lpf_mc (directed + random stimulus
//            against a serial per-channel filter model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_iir1_lpf_mc;
  localparam int DW  = 8;
  localparam int CW  = 2;
  localparam int CH  = 5;
  localparam int CHW = 3;
  localparam int N   = 4096;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           i_clr = 1'b0;
  logic           i_valid = 1'b0;
  logic [CHW-1:0] i_ch = '0;
  logic [DW-1:0]  i_data = '0;
  logic [CW:0]    i_coef = '0;
  logic           o_valid;
  logic [CHW-1:0] o_ch;
  logic [DW-1:0]  o_y;

  iir1_lpf_mc #(.DW(DW), .CW(CW), .CH(CH)) dut (
    .clk(clk), .rst_n(rst_n), .i_clr(i_clr), .i_valid(i_valid),
    .i_ch(i_ch), .i_data(i_data), .i_coef(i_coef),
    .o_valid(o_valid), .o_ch(o_ch), .o_y(o_y)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int sm [CH];
  bit ev [N];
  int ey [N];
  int ech [N];
  int last_y = 0;
  int last_ch = 0;
  int got [$];
  int want [$];
  bit rec = 1'b0;

  // Serial filter: exact result of processing samples one at a time
  function automatic int filt(int c, int x, int coef);
    int one = 1 << CW;
    int a = (coef > one) ? one : coef;
    int prod = a * x * one + (one - a) * sm[c];
    int y;
`ifdef IIR1_ROUND_EN
    sm[c] = (prod + one / 2) / one;
    y = (sm[c] + one / 2) / one;
    if (y > (1 << DW) - 1) y = (1 << DW) - 1;
`else
    sm[c] = prod / one;
    y = sm[c] / one;
`endif
    return y;
  endfunction

  task automatic check_cycle();
    int k = cyc % N;
    if (ev[k]) begin
      last_y  = ey[k];
      last_ch = ech[k];
    end
    checks++;
    assert (o_valid === ev[k]) else begin
      errors++;
      $error("FAIL o_valid cyc=%0d got=%b exp=%b", cyc, o_valid, ev[k]);
    end
    checks++;
    assert (o_y === DW'(last_y)) else begin
      errors++;
      $error("FAIL o_y cyc=%0d got=%0d exp=%0d", cyc, o_y, last_y);
    end
    checks++;
    assert (o_ch === CHW'(last_ch)) else begin
      errors++;
      $error("FAIL o_ch cyc=%0d got=%0d exp=%0d", cyc, o_ch, last_ch);
    end
    if (rec && o_valid === 1'b1) got.push_back(int'(o_y));
    ev[k] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic drive(bit v, int ch, int x, int coef, bit clr);
    i_valid = v;
    i_ch    = CHW'(ch);
    i_data  = DW'(x);
    i_coef  = (CW + 1)'(coef);
    i_clr   = clr;
    if (clr) begin
      for (int c = 0; c < CH; c++) sm[c] = 0;
      ev[(cyc + 1) % N] = 1'b0;
      ev[(cyc + 2) % N] = 1'b0;
    end else if (v && ch < CH) begin
      int k = (cyc + 3) % N;
      ey[k]  = filt(ch, x, coef);
      ech[k] = ch;
      ev[k]  = 1'b1;
    end
    tick();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    assert (o_valid === 1'b0 && o_y === '0 && o_ch === '0) else begin
      errors++;
      $error("FAIL async_reset got v=%b y=%0d ch=%0d exp v=0 y=0 ch=0", o_valid, o_y, o_ch);
    end
    for (int c = 0; c < CH; c++) sm[c] = 0;
    for (int i = 0; i < 4; i++) ev[(cyc + i) % N] = 1'b0;
    last_y = 0;
    last_ch = 0;
    i_valid = 1'b0;
    i_clr = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic start_rec();
    got.delete();
    rec = 1'b1;
  endtask

  task automatic check_seq(string tag);
    rec = 1'b0;
    checks++;
    assert (got.size() == want.size()) else begin
      errors++;
      $error("FAIL %s count got=%0d exp=%0d", tag, got.size(), want.size());
    end
    if (got.size() == want.size()) begin
      for (int i = 0; i < want.size(); i++) begin
        checks++;
        assert (got[i] == want[i]) else begin
          errors++;
          $error("FAIL %s[%0d] got=%0d exp=%0d", tag, i, got[i], want[i]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state held for a few cycles
    for (int c = 0; c < CH; c++) sm[c] = 0;
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    idle(2);

    // Back-to-back same channel: forwarding path
    start_rec();
    for (int i = 0; i < 3; i++) drive(1'b1, 0, 100, 3, 1'b0);
    idle(4);
`ifndef IIR1_ROUND_EN
    want = '{75, 93, 98};
    check_seq("b2b_ch0");
`else
    rec = 1'b0;
`endif

    // Interleaved channels stay independent
    drive(1'b1, 0, 0, 4, 1'b0);
    idle(3);
    async_reset();
    idle(1);
    start_rec();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 0, 100, 3, 1'b0);
      drive(1'b1, 1, 200, 4, 1'b0);
    end
    idle(4);
`ifndef IIR1_ROUND_EN
    want = '{75, 200, 93, 200, 98, 200};
    check_seq("interleave");
`else
    rec = 1'b0;
`endif

    // a = 0 holds the previous output; coef above 2^CW clamps to pass-through
    start_rec();
    drive(1'b1, 2, 50, 4, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 2, 255, 0, 1'b0);
    drive(1'b1, 2, 123, 7, 1'b0);
    drive(1'b1, 2, 9, 5, 1'b0);
    idle(4);
    want = '{50, 50, 50, 50, 123, 9};
    check_seq("coef_edges");

    // Clear together with a sample, then restart from zero state
    for (int i = 0; i < 3; i++) drive(1'b1, 0, 100, 3, 1'b0);
    idle(4);
    start_rec();
    drive(1'b1, 0, 100, 3, 1'b1);
    drive(1'b1, 0, 100, 3, 1'b0);
    idle(4);
    want = '{75};
    check_seq("clr_restart");

    // Clear while samples are in flight: none of them may emerge
    start_rec();
    drive(1'b1, 1, 200, 4, 1'b0);
    drive(1'b1, 3, 40, 2, 1'b0);
    drive(1'b0, 0, 0, 0, 1'b1);
    idle(4);
    want = '{};
    check_seq("clr_inflight");

    // Out-of-range channels are dropped without touching any state
    start_rec();
    drive(1'b1, 5, 77, 4, 1'b0);
    drive(1'b1, 6, 88, 4, 1'b0);
    drive(1'b1, 7, 99, 4, 1'b0);
    drive(1'b1, 4, 60, 0, 1'b0);
    idle(4);
    want = '{0};
    check_seq("bad_ch");

    // Asynchronous reset with work in flight
    drive(1'b1, 0, 100, 3, 1'b0);
    drive(1'b1, 1, 150, 2, 1'b0);
    async_reset();
    start_rec();
    drive(1'b1, 0, 100, 3, 1'b0);
    idle(4);
    want = '{75};
    check_seq("after_reset");

    // Random traffic, biased toward back-to-back reuse of low channels
    for (int i = 0; i < 1500; i++) begin
      int ch = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 2));
      bit v = ($urandom_range(0, 4) != 0);
      bit clr = ($urandom_range(0, 59) == 0);
      drive(v, ch, int'($urandom_range(0, 255)), int'($urandom_range(0, 7)), clr);
    end
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
